// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: register numbering, FSM state
// encoding, the FD source payload and the perf counter width.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned PERF_W = 16;

    // r0 is hardwired to zero and never produces a hazard
    localparam logic [REG_W-1:0] REG_R0 = REG_W'(0);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    typedef struct packed {
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic             src_a_vld;
        logic             src_b_vld;
    } fd_src_t;

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Load-use comparator: a load in DX whose destination is read by the
// instruction in FD.
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  fd_src_t          i_fd,
    input  logic             i_lw_dx,
    input  logic [REG_W-1:0] i_rd_dx,
    output logic             o_hazard_c
);

    logic w_match_a;
    logic w_match_b;

    assign w_match_a  = i_fd.src_a_vld && (i_fd.src_a == i_rd_dx);
    assign w_match_b  = i_fd.src_b_vld && (i_fd.src_b == i_rd_dx);
    assign o_hazard_c = i_lw_dx && (i_rd_dx != REG_R0) && (w_match_a || w_match_b);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, load-use stall and multdiv wait
// with timeout. Define HAZARD_PERF_CNT_EN to add the stall_cnt perf counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 40
) (
    input  logic             rise,
    input  logic             reset,
    input  logic [REG_W-1:0] src_a_fd,
    input  logic [REG_W-1:0] src_b_fd,
    input  logic             src_a_vld,
    input  logic             src_b_vld,
    input  logic             lw_dx,
    input  logic [REG_W-1:0] rd_dx,
    input  logic             md_start_dx,
    input  logic             md_ready,
    input  logic             redirect_x,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             bubble_dx,
    output logic             flush_fd,
    output logic             md_busy,
    output logic             md_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    localparam int unsigned      CNT_W    = $clog2(MD_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] w_md_cnt_nxt;
    logic             r_md_err;
    logic             w_md_err_nxt;
    logic             w_hazard;
    fd_src_t          w_fd;

    assign w_fd = '{src_a: src_a_fd, src_b: src_b_fd,
                    src_a_vld: src_a_vld, src_b_vld: src_b_vld};

    hazard_cmp u_cmp (
        .i_fd       (w_fd),
        .i_lw_dx    (lw_dx),
        .i_rd_dx    (rd_dx),
        .o_hazard_c (w_hazard)
    );

    // State, wait counter and sticky timeout flag
    always_ff @(posedge rise or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_md_cnt <= '0;
            r_md_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            r_md_err <= w_md_err_nxt;
        end
    end

    // Next state and zero-latency pipeline controls
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        w_md_err_nxt = r_md_err;
        stall_pc     = 1'b0;
        stall_fd     = 1'b0;
        bubble_dx    = 1'b0;
        flush_fd     = 1'b0;
        md_busy      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect_x) begin
                    flush_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end else if (md_start_dx) begin
                    stall_pc     = 1'b1;
                    stall_fd     = 1'b1;
                    w_state_nxt  = ST_MD_WAIT;
                    w_md_cnt_nxt = '0;
                end else if (w_hazard) begin
                    stall_pc  = 1'b1;
                    stall_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                stall_pc     = 1'b1;
                stall_fd     = 1'b1;
                bubble_dx    = 1'b1;
                md_busy      = 1'b1;
                w_md_cnt_nxt = r_md_cnt + CNT_W'(1);
                // a result arriving on the last allowed cycle beats the timeout
                if (md_ready) begin
                    w_state_nxt = ST_RUN;
                end else if (r_md_cnt == CNT_LAST) begin
                    w_md_err_nxt = 1'b1;
                    w_state_nxt  = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign md_err = r_md_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cnt;

    // Saturating count of PC-stall cycles
    always_ff @(posedge rise or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall_pc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected control vectors,
// a monitor pops and compares them mid-cycle.
module tb_hazard_ctrl;

    logic       rise;
    logic       reset;
    logic [4:0] src_a_fd;
    logic [4:0] src_b_fd;
    logic       src_a_vld;
    logic       src_b_vld;
    logic       lw_dx;
    logic [4:0] rd_dx;
    logic       md_start_dx;
    logic       md_ready;
    logic       redirect_x;
    logic       stall_pc;
    logic       stall_fd;
    logic       bubble_dx;
    logic       flush_fd;
    logic       md_busy;
    logic       md_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    // {stall_pc, stall_fd, bubble_dx, flush_fd, md_busy, md_err}
    localparam logic [5:0] E_IDLE   = 6'b000000;
    localparam logic [5:0] E_LU     = 6'b111000;
    localparam logic [5:0] E_RD     = 6'b001100;
    localparam logic [5:0] E_MDS    = 6'b110000;
    localparam logic [5:0] E_WAIT   = 6'b111010;
    localparam logic [5:0] E_ERR    = 6'b000001;
    localparam logic [5:0] E_LU_ERR = 6'b111001;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [5:0] exp_q[$];
    string      tag_q[$];

    hazard_ctrl #(.MD_TIMEOUT(40)) dut (
        .rise        (rise),
        .reset       (reset),
        .src_a_fd    (src_a_fd),
        .src_b_fd    (src_b_fd),
        .src_a_vld   (src_a_vld),
        .src_b_vld   (src_b_vld),
        .lw_dx       (lw_dx),
        .rd_dx       (rd_dx),
        .md_start_dx (md_start_dx),
        .md_ready    (md_ready),
        .redirect_x  (redirect_x),
        .stall_pc    (stall_pc),
        .stall_fd    (stall_fd),
        .bubble_dx   (bubble_dx),
        .flush_fd    (flush_fd),
        .md_busy     (md_busy),
        .md_err      (md_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial begin
        rise = 1'b0;
        forever #5 rise = ~rise;
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue its expected outputs
    task automatic step(input string tag,
                        input logic [4:0] a, input logic av,
                        input logic [4:0] b, input logic bv,
                        input logic lw, input logic [4:0] rd,
                        input logic mds, input logic mdr, input logic redir,
                        input logic [5:0] exp);
        @(negedge rise);
        src_a_fd    = a;
        src_a_vld   = av;
        src_b_fd    = b;
        src_b_vld   = bv;
        lw_dx       = lw;
        rd_dx       = rd;
        md_start_dx = mds;
        md_ready    = mdr;
        redirect_x  = redir;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic step_idle(input string tag, input logic [5:0] exp);
        step(tag, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic step_lu(input string tag, input logic [5:0] exp);
        step(tag, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic step_md_start(input string tag);
        step(tag, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDS);
    endtask

    // Monitor: compare the oldest expectation two time units after each falling edge
    initial begin
        forever begin
            @(negedge rise);
            #2;
            if (exp_q.size() != 0) begin
                logic [5:0] e;
                string      t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check_eq(t, 16'({stall_pc, stall_fd, bubble_dx, flush_fd, md_busy, md_err}), 16'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        src_a_fd    = 5'd0;
        src_b_fd    = 5'd0;
        src_a_vld   = 1'b0;
        src_b_vld   = 1'b0;
        lw_dx       = 1'b0;
        rd_dx       = 5'd0;
        md_start_dx = 1'b0;
        md_ready    = 1'b0;
        redirect_x  = 1'b0;

        // Reset: registered state clear, RUN-state combinational paths live
        step_idle("rst_idle", E_IDLE);
        step_lu("rst_lu", E_LU);
        @(negedge rise);
        reset = 1'b1;

        // Load-use, r0, invalid sources, priority
        step_lu("lu_a", E_LU);
        step_idle("lu_clear", E_IDLE);
        step("lu_b", 5'd3, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_LU);
        step("r0", 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("inv_src", 5'd5, 1'b0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("no_lw", 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("redir_lu", 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, E_RD);
        step("md_lu", 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_MDS);
        for (int i = 0; i < 2; i++) step_idle("md_pre", E_WAIT);
        step("md_pre_rdy", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_WAIT);
        step("rdy_in_run", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_IDLE);

        // Multdiv completing after 17 wait cycles; RUN-state events ignored meanwhile
        step_md_start("md_start");
        for (int i = 0; i < 17; i++) begin
            if (i == 3)
                step("md_ign_lu", 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, E_WAIT);
            else if (i == 5)
                step("md_ign_start", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, E_WAIT);
            else
                step("md_wait", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, i == 16, 1'b0, E_WAIT);
        end
        step_idle("md_done", E_IDLE);

        // Timeout after 40 wait cycles; flag is sticky
        step_md_start("to_start");
        for (int i = 0; i < 40; i++) step_idle("to_wait", E_WAIT);
        step_idle("to_err", E_ERR);
        step_lu("err_held_lu", E_LU_ERR);
        step_idle("err_held", E_ERR);

        // md_ready on the final allowed cycle beats the timeout
        @(negedge rise);
        reset = 1'b0;
        step_idle("rst_clr", E_IDLE);
        @(negedge rise);
        reset = 1'b1;
        step_md_start("rl_start");
        for (int i = 0; i < 40; i++)
            step("rl_wait", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, i == 39, 1'b0, E_WAIT);
        step_idle("rl_done", E_IDLE);

        // Asynchronous reset in the middle of a multdiv wait
        step_md_start("mr_start");
        for (int i = 0; i < 5; i++) step_idle("mr_wait", E_WAIT);
        @(posedge rise);
        #2;
        reset = 1'b0;
        step_idle("rst_mid", E_IDLE);
`ifdef HAZARD_PERF_CNT_EN
        #3;
        check_eq("cnt_rst", stall_cnt, 16'd0);
`endif
        @(negedge rise);
        reset = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
        for (int i = 0; i < 3; i++) step_lu("cnt_lu", E_LU);
        step_idle("cnt_idle", E_IDLE);
        #3;
        check_eq("cnt_three", stall_cnt, 16'd3);
`endif
        step_idle("tail", E_IDLE);
        @(negedge rise);
        #4;
        check_eq("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 40: the maximum number of cycles spent in MD_WAIT before a multdiv timeout is declared.
REQ-002 SHALL have port rise, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports src_a_fd and src_b_fd, inputs, 5 bits each: source register numbers of the instruction in FD.
REQ-005 SHALL have ports src_a_vld and src_b_vld, inputs, 1 bit each: the corresponding FD source is actually read.
REQ-006 SHALL have ports lw_dx (input, 1 bit) and rd_dx (input, 5 bits): the DX instruction is a load, and its destination register.
REQ-007 SHALL have port md_start_dx, input, 1 bit: a mult/div instruction is in DX and starts this cycle.
REQ-008 SHALL have port md_ready, input, 1 bit: the multdiv unit's result is valid.
REQ-009 SHALL have port redirect_x, input, 1 bit: a taken branch, jr or bex was resolved in X.
REQ-010 SHALL have ports stall_pc and stall_fd, outputs, 1 bit each: hold the PC register and hold the FD registers (enable = ~stall).
REQ-011 SHALL have ports bubble_dx and flush_fd, outputs, 1 bit each: insert a nop into DX, and replace the FD contents with a nop.
REQ-012 SHALL have ports md_busy and md_err, outputs, 1 bit each: multdiv in progress, and sticky timeout flag.

Function
REQ-013 SHALL implement a two-state FSM, RUN and MD_WAIT, with a counter md_cnt of width clog2(MD_TIMEOUT)+1.
REQ-014 SHALL define load-use hazard = lw_dx & (rd_dx != 0) & ((src_a_vld & src_a_fd == rd_dx) | (src_b_vld & src_b_fd == rd_dx)).
REQ-015 SHALL, in RUN, apply these cases in priority order, all combinational with zero latency:
  - redirect_x: flush_fd=1, bubble_dx=1, no stall.
  - md_start_dx: stall_pc=stall_fd=1; next state MD_WAIT; md_cnt cleared to 0.
  - load-use hazard: stall_pc=stall_fd=bubble_dx=1 for exactly one cycle.
  - otherwise: all control outputs 0.
REQ-016 SHALL, in MD_WAIT, assert stall_pc=stall_fd=bubble_dx=1 and md_busy=1, and increment md_cnt each cycle.
REQ-017 SHALL leave MD_WAIT for RUN on the cycle after md_ready=1; stalls drop in that RUN cycle.
REQ-018 SHALL, when md_cnt==MD_TIMEOUT-1 without md_ready, set md_err=1 and return to RUN; md_err stays set until reset.
REQ-019 SHALL give md_ready priority over timeout when both occur in the same cycle; md_err stays 0.
REQ-020 SHALL ignore redirect_x, md_start_dx and load-use hazards while in MD_WAIT.
REQ-021 SHALL ignore md_ready while in RUN.
REQ-022 SHALL suppress the load-use hazard when rd_dx==0 (r0 is never written).

Reset
REQ-023 SHALL, on reset low, asynchronously force: state RUN, md_cnt 0, md_err 0, perf counter 0.
REQ-024 SHALL hold all outputs at 0 during reset, except combinational outputs driven by RUN-state inputs.
REQ-025 SHALL, when reset is asserted mid-MD_WAIT, drop all stalls immediately.

Configuration
REQ-026 SHALL, with HAZARD_PERF_CNT_EN defined, add output stall_cnt (16 bits): counts cycles with stall_pc=1, saturating at 0xFFFF.
REQ-027 SHALL, without HAZARD_PERF_CNT_EN, omit the stall_cnt port and counter entirely; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state enum (RUN, MD_WAIT) and the r0 register number constant in the shared cpu package.
REQ-029 SHALL implement the comparator of REQ-014 as sub-module hazard_cmp; the FSM and counters stay in hazard_ctrl.

Verification
REQ-030 SHALL cover load-use: lw_dx=1, rd_dx=5, src_a_fd=5, src_a_vld=1 -> stall_pc/stall_fd/bubble_dx=1 for one cycle, then 0.
REQ-031 SHALL cover r0 and invalid sources: rd_dx=0 matching, or a match with src_vld=0 -> no stall.
REQ-032 SHALL cover priority: redirect_x and load-use hazard together -> flush_fd=1, bubble_dx=1, stall_pc=0.
REQ-033 SHALL cover multdiv: md_start_dx pulse, md_ready after 17 cycles -> md_busy high 17 cycles, stalls drop on the next cycle, md_err=0.
REQ-034 SHALL cover timeout: md_start_dx, no md_ready, MD_TIMEOUT=40 -> md_err=1 after 40 MD_WAIT cycles, state RUN, md_err held; md_ready on the final cycle -> md_err=0.
REQ-035 SHALL cover reset mid-MD_WAIT (cycle 5): reset low -> md_busy=0, stalls 0 asynchronously; with HAZARD_PERF_CNT_EN, stall_cnt=0.
